// File: rtl/vga_timing_gen_if.sv
// Timing bus between the video timing generator and its consumers.
// The master drives the raster position and syncs. The slave drives the ce/run controls.
interface vga_timing_gen_if #(
  parameter int FC_W = 8
);
  logic            ce;
  logic            run;
  logic [11:0]     pixel_x;
  logic [11:0]     pixel_y;
  logic            de;
  logic            hsync;
  logic            vsync;
  logic            line_start;
  logic            frame_start;
  logic [FC_W-1:0] frame_count;

  modport master (
    input  ce, run,
    output pixel_x, pixel_y, de, hsync, vsync, line_start, frame_start, frame_count
  );

  modport slave (
    output ce, run,
    input  pixel_x, pixel_y, de, hsync, vsync, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Video timing generator with a pixel clock-enable, run/stop control and a sync/DE delay line.
// The delay line lets the sync outputs line up with a pixel pipeline of known depth.
module vga_timing_gen #(
  parameter int   H_DISP     = 640,
  parameter int   H_FP       = 10,
  parameter int   H_SYNC     = 56,
  parameter int   H_BP       = 62,
  parameter int   V_DISP     = 576,
  parameter int   V_FP       = 21,
  parameter int   V_SYNC     = 5,
  parameter int   V_BP       = 22,
  parameter logic HS_POL     = 1'b0,
  parameter logic VS_POL     = 1'b0,
  parameter int   SYNC_DELAY = 2,
  parameter int   FC_W       = 8
) (
  input logic             clk,
  input logic             reset,
  vga_timing_gen_if.master bus
);
  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 4096) begin : g_bad_h
    $error("vga_timing_gen: H_TOTAL exceeds 4096");
  end
  if (V_TOTAL > 4096) begin : g_bad_v
    $error("vga_timing_gen: V_TOTAL exceeds 4096");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 15) begin : g_bad_d
    $error("vga_timing_gen: SYNC_DELAY must be 0..15");
  end

  // Stage fields are active-high. Polarity is applied only at the pins.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
  } stg_t;

  logic [11:0]            h_cnt, v_cnt;
  logic [FC_W-1:0]        fc;
  stg_t [SYNC_DELAY:0]    stg_q;
  stg_t                   dec;
  logic                   ce_q;
  logic                   h_end, v_end;

  assign h_end = (int'(h_cnt) == H_TOTAL - 1);
  assign v_end = (int'(v_cnt) == V_TOTAL - 1);

  always_comb begin
    dec    = '0;
    dec.de = (int'(h_cnt) < H_DISP) && (int'(v_cnt) < V_DISP);
    dec.hs = (int'(h_cnt) >= H_DISP + H_FP) && (int'(h_cnt) < H_DISP + H_FP + H_SYNC);
    dec.vs = (int'(v_cnt) >= V_DISP + V_FP) && (int'(v_cnt) < V_DISP + V_FP + V_SYNC);
    dec.ls = (h_cnt == '0);
    dec.fs = (h_cnt == '0) && (v_cnt == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
      fc    <= '0;
      stg_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      ce_q <= bus.ce;
      // A frame wrap still counts on the same edge where run drops.
      if (bus.ce && h_end && v_end) fc <= fc + 1'b1;
      if (!bus.run) begin
        h_cnt <= '0;
        v_cnt <= '0;
        stg_q <= '0;
      end else if (bus.ce) begin
        if (h_end) begin
          h_cnt <= '0;
          v_cnt <= v_end ? 12'd0 : v_cnt + 12'd1;
        end else begin
          h_cnt <= h_cnt + 12'd1;
        end
        stg_q[0] <= dec;
        for (int i = 1; i <= SYNC_DELAY; i++) stg_q[i] <= stg_q[i-1];
      end
    end
  end

  assign bus.pixel_x     = h_cnt;
  assign bus.pixel_y     = v_cnt;
  assign bus.de          = stg_q[SYNC_DELAY].de;
  assign bus.hsync       = stg_q[SYNC_DELAY].hs ? HS_POL : ~HS_POL;
  assign bus.vsync       = stg_q[SYNC_DELAY].vs ? VS_POL : ~VS_POL;
  // Gating with the registered ce makes each strobe exactly one clk wide when ce is sparse.
  assign bus.line_start  = stg_q[SYNC_DELAY].ls & ce_q;
  assign bus.frame_start = stg_q[SYNC_DELAY].fs & ce_q;
  assign bus.frame_count = fc;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a 16x8 raster. Two instances are used, one with no sync delay and one with a delay of 3.
// A frame-index reference model is checked on every edge, alongside table vectors and corner sequences.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ce = 1'b1;
  logic run = 1'b1;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.FC_W(8)) b0 ();
  vga_timing_gen_if #(.FC_W(8)) b3 ();
  assign b0.ce  = ce;
  assign b0.run = run;
  assign b3.ce  = ce;
  assign b3.run = run;

  vga_timing_gen #(.H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_DISP(4), .V_FP(1), .V_SYNC(2),
    .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .SYNC_DELAY(0), .FC_W(8))
    dut0 (.clk(clk), .reset(reset), .bus(b0));
  vga_timing_gen #(.H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_DISP(4), .V_FP(1), .V_SYNC(2),
    .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .SYNC_DELAY(3), .FC_W(8))
    dut3 (.clk(clk), .reset(reset), .bus(b3));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a linear position within the 128-pixel frame, plus a history of decoded events.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
  } sig_t;

  sig_t hist [4];
  int   pos;
  int   fc;
  logic ceq;

  function automatic sig_t decode(input int p);
    sig_t s;
    int h, v;
    h = p % 16;
    v = p / 16;
    s.de = (h < 8) && (v < 4);
    s.hs = (h >= 10) && (h < 13);
    s.vs = (v >= 5) && (v < 7);
    s.ls = (h == 0);
    s.fs = (p == 0);
    return s;
  endfunction

  task automatic model_reset();
    pos = 0;
    fc  = 0;
    ceq = 1'b0;
    for (int i = 0; i < 4; i++) hist[i] = '0;
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else begin
      if (!run) begin
        if (ce && pos == 127) fc = (fc + 1) % 256;
        pos = 0;
        for (int i = 0; i < 4; i++) hist[i] = '0;
      end else if (ce) begin
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = decode(pos);
        if (pos == 127) fc = (fc + 1) % 256;
        pos = (pos + 1) % 128;
      end
      ceq = ce;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("x0", int'(b0.pixel_x), pos % 16);
    chk("y0", int'(b0.pixel_y), pos / 16);
    chk("x3", int'(b3.pixel_x), pos % 16);
    chk("y3", int'(b3.pixel_y), pos / 16);
    chk("fc0", int'(b0.frame_count), fc);
    chk("fc3", int'(b3.frame_count), fc);
    chk("de0", int'(b0.de), int'(hist[0].de));
    chk("hs0", int'(b0.hsync), int'(!hist[0].hs));
    chk("vs0", int'(b0.vsync), int'(!hist[0].vs));
    chk("ls0", int'(b0.line_start), int'(hist[0].ls & ceq));
    chk("fs0", int'(b0.frame_start), int'(hist[0].fs & ceq));
    chk("de3", int'(b3.de), int'(hist[3].de));
    chk("hs3", int'(b3.hsync), int'(!hist[3].hs));
    chk("vs3", int'(b3.vsync), int'(!hist[3].vs));
    chk("ls3", int'(b3.line_start), int'(hist[3].ls & ceq));
    chk("fs3", int'(b3.frame_start), int'(hist[3].fs & ceq));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_pos(input int p, input string nm);
    int k;
    k = 0;
    while (pos != p && k < 300) begin
      tick();
      k++;
    end
    chk(nm, int'(b0.pixel_y) * 16 + int'(b0.pixel_x), p);
  endtask

  typedef struct {
    int   n;
    int   x, y;
    logic de, hs, vs, ls, fs;
    int   fc;
  } vec_t;

  vec_t tbl [$];
  int   e;
  int   saved;
  int   cnt;

  initial begin
    // n, pixel_x, pixel_y, de, hsync, vsync, line_start, frame_start, frame_count
    tbl.push_back('{1,   1,  0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0});
    tbl.push_back('{2,   2,  0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{8,   8,  0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{9,   9,  0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{11,  11, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{13,  13, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{14,  14, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{17,  1,  1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0});
    tbl.push_back('{65,  1,  4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0});
    tbl.push_back('{80,  0,  5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{81,  1,  5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0});
    tbl.push_back('{111, 15, 6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{112, 0,  7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{113, 1,  7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0});
    tbl.push_back('{128, 0,  0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1});
    tbl.push_back('{129, 1,  0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1});

    model_reset();
    tick();
    tick();
    chk("rst_de", int'(b0.de), 0);
    chk("rst_hs", int'(b0.hsync), 1);
    chk("rst_vs", int'(b3.vsync), 1);
    chk("rst_ls", int'(b0.line_start), 0);
    chk("rst_fc", int'(b0.frame_count), 0);
    reset = 1'b0;

    // Table vectors, counted in edges after reset release.
    e = 0;
    foreach (tbl[k]) begin
      while (e < tbl[k].n) begin
        tick();
        e++;
      end
      chk($sformatf("tbl%0d_x", tbl[k].n), int'(b0.pixel_x), tbl[k].x);
      chk($sformatf("tbl%0d_y", tbl[k].n), int'(b0.pixel_y), tbl[k].y);
      chk($sformatf("tbl%0d_de", tbl[k].n), int'(b0.de), int'(tbl[k].de));
      chk($sformatf("tbl%0d_hs", tbl[k].n), int'(b0.hsync), int'(tbl[k].hs));
      chk($sformatf("tbl%0d_vs", tbl[k].n), int'(b0.vsync), int'(tbl[k].vs));
      chk($sformatf("tbl%0d_ls", tbl[k].n), int'(b0.line_start), int'(tbl[k].ls));
      chk($sformatf("tbl%0d_fs", tbl[k].n), int'(b0.frame_start), int'(tbl[k].fs));
      chk($sformatf("tbl%0d_fc", tbl[k].n), int'(b0.frame_count), tbl[k].fc);
    end

    // With a delay of 3, the first active pixel appears 3 edges after it does with no delay.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("d3_x", int'(b3.pixel_x), i);
      chk("d3_de", int'(b3.de), (i == 4) ? 1 : 0);
      chk("d3_fs", int'(b3.frame_start), (i == 4) ? 1 : 0);
    end

    // Drop run at h=5, v=2, then reassert it.
    wait_pos(37, "wait_h5v2");
    saved = int'(b0.frame_count);
    run = 1'b0;
    tick();
    chk("stop_x", int'(b0.pixel_x), 0);
    chk("stop_y", int'(b0.pixel_y), 0);
    chk("stop_de", int'(b0.de), 0);
    chk("stop_hs", int'(b0.hsync), 1);
    chk("stop_vs", int'(b0.vsync), 1);
    chk("stop_fc", int'(b0.frame_count), saved);
    run = 1'b1;
    tick();
    chk("rerun_de", int'(b0.de), 1);
    chk("rerun_ls", int'(b0.line_start), 1);

    // Frame wrap on the same edge as run=0: the counters clear and the frame counter still advances.
    wait_pos(127, "wait_last");
    saved = int'(b0.frame_count);
    run = 1'b0;
    tick();
    chk("wrapstop_fc", int'(b0.frame_count), (saved + 1) % 256);
    chk("wrapstop_x", int'(b0.pixel_x), 0);
    chk("wrapstop_fs", int'(b0.frame_start), 0);
    run = 1'b1;

    // With ce alternating, the period doubles and each strobe stays one clk wide.
    do_reset();
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      ce = (i % 2 == 0);
      tick();
      if (b0.line_start) cnt++;
      chk("ce_x", int'(b0.pixel_x), ((i + 2) / 2) % 16);
    end
    chk("ce_ls_cycles", cnt, 2);
    ce = 1'b1;

    // Assert reset asynchronously in the middle of hsync.
    cnt = 0;
    while (!hist[0].hs && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("wait_hs", int'(b0.hsync), 0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("arst_hs", int'(b0.hsync), 1);
    chk("arst_de", int'(b0.de), 0);
    chk("arst_ls", int'(b0.line_start), 0);
    check_all();
    tick();
    reset = 1'b0;
    chk("arst_x", int'(b0.pixel_x), 0);
    chk("arst_y", int'(b0.pixel_y), 0);

    // Random ce/run activity, checked against the model.
    for (int i = 0; i < 3000; i++) begin
      ce  = ($urandom_range(0, 3) != 0);
      run = ($urandom_range(0, 63) != 0);
      tick();
    end

    // Run 256 full frames to take the frame counter through 255 and back to 0.
    ce  = 1'b1;
    run = 1'b1;
    do_reset();
    for (int i = 1; i <= 256 * 128; i++) begin
      tick();
      if (i == 255 * 128) chk("fc_255", int'(b0.frame_count), 255);
    end
    chk("fc_wrap", int'(b0.frame_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
